// File: rtl/cluster_clock_gating_cell.sv
// Latch-based glitch-free clock gate with optional enable hold-off
// and an FPGA bypass that passes the source clock straight through.
module cluster_clock_gating_cell #(
    parameter bit FPGA_BYPASS = 1'b0,
    parameter int HOLD_CYCLES = 0,
    parameter int HOLD_W      = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    generate
        if (FPGA_BYPASS) begin : g_bypass
            assign clk_o = clk_i;
        end else begin : g_gate
            logic [HOLD_W-1:0] w_hold_cnt;
            logic              w_en_eff;

            if (HOLD_CYCLES > 0) begin : g_hold
                logic [HOLD_W-1:0] r_hold_cnt;

                always_ff @(posedge clk_i or negedge rst_n) begin
                    if (!rst_n) begin
                        r_hold_cnt <= '0;
                    end else if (en_i) begin
                        r_hold_cnt <= HOLD_W'(HOLD_CYCLES);
                    end else if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end

                assign w_hold_cnt = r_hold_cnt;
            end else begin : g_no_hold
                assign w_hold_cnt = '0;
            end

            assign w_en_eff = en_i | test_en_i | (w_hold_cnt != '0);

`ifdef CCGC_TECH_ICG_CELL
            ccgc_tech_icg u_icg (
                .clk_i (clk_i),
                .rst_n (rst_n),
                .en_i  (w_en_eff),
                .clk_o (clk_o)
            );
`else
            logic r_en_lat;

            // Opaque while clk_i is high, so a release mid-high cannot
            // open the gate before the next low phase.
            always_latch begin
                if (!rst_n) begin
                    r_en_lat <= 1'b0;
                end else if (!clk_i) begin
                    r_en_lat <= w_en_eff;
                end
            end

            assign clk_o = clk_i & r_en_lat;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_cluster_clock_gating_cell.sv
// Directed bench for the clock gate: plain, hold-of-2 and bypass builds.
module tb_cluster_clock_gating_cell;

    logic clk;
    logic rst_n;
    logic en, te;
    logic h_en, h_te;
    logic b_rst, b_en, b_te;
    logic c0, ch, cb;

    int p0, n0, ph, pb, pk;
    int n_pass, n_tot;

    typedef struct {
        logic en;
        logic te;
        logic h_en;
        logic exp;
        logic h_exp;
    } vec_t;

    vec_t tbl[18];

    cluster_clock_gating_cell u_dut (
        .clk_i(clk), .rst_n(rst_n), .en_i(en), .test_en_i(te), .clk_o(c0)
    );

    cluster_clock_gating_cell #(.HOLD_CYCLES(2)) u_hold (
        .clk_i(clk), .rst_n(rst_n), .en_i(h_en), .test_en_i(h_te), .clk_o(ch)
    );

    cluster_clock_gating_cell #(.FPGA_BYPASS(1'b1)) u_byp (
        .clk_i(clk), .rst_n(b_rst), .en_i(b_en), .test_en_i(b_te), .clk_o(cb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        p0 = 0; n0 = 0; ph = 0; pb = 0; pk = 0;
    end

    always @(posedge c0)  p0 <= p0 + 1;
    always @(negedge c0)  n0 <= n0 + 1;
    always @(posedge ch)  ph <= ph + 1;
    always @(posedge cb)  pb <= pb + 1;
    always @(posedge clk) pk <= pk + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_tot++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        int s0, sh;
        @(negedge clk);
        #1;
        en = v.en; te = v.te; h_en = v.h_en;
        s0 = p0; sh = ph;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d lvl_early", i), int'(c0), int'(v.exp));
        chk($sformatf("vec%0d hold_early", i), int'(ch), int'(v.h_exp));
        #3;
        chk($sformatf("vec%0d lvl_late", i), int'(c0), int'(v.exp));
        chk($sformatf("vec%0d pulses", i), p0 - s0, int'(v.exp));
        chk($sformatf("vec%0d hold_pulses", i), ph - sh, int'(v.h_exp));
    endtask

    initial begin
        int s, k;
        n_pass = 0; n_tot = 0;

        //        en    te    h_en  exp   h_exp
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; en = 1'b1; te = 1'b1;
        h_en = 1'b1; h_te = 1'b0;
        b_rst = 1'b0; b_en = 1'b0; b_te = 1'b0;

        // Held in reset with both enables high: no clock at all.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        chk("reset clk_o", int'(c0), 0);
        chk("reset hold clk_o", int'(ch), 0);
        chk("reset edges", p0, 0);
        chk("bypass in reset hi", int'(cb), 1);

        @(negedge clk);
        #1;
        rst_n = 1'b1; te = 1'b0; h_en = 1'b0;
        @(posedge clk);
        #1;
        chk("first pulse after release", int'(c0), 1);
        chk("hold idle after release", int'(ch), 0);

        // Assert reset mid-high: gate must close immediately.
        te = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset mid-high drop", int'(c0), 0);
        @(posedge clk);
        #2;
        chk("reset held with test_en", int'(c0), 0);

        // Release mid-high: no runt pulse, next full high phase passes.
        s = p0;
        rst_n = 1'b1;
        #1;
        chk("release mid-high no runt", int'(c0), 0);
        @(posedge clk);
        #1;
        chk("first full pulse", int'(c0), 1);
        chk("single edge after release", p0 - s, 1);
        te = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // Scan override for 10 cycles.
        @(negedge clk);
        #1;
        en = 1'b0; te = 1'b1; h_en = 1'b0;
        s = p0; k = pk;
        repeat (10) @(posedge clk);
        #1;
        chk("test_en pulses", p0 - s, 10);
        chk("test_en vs clk", p0 - s, pk - k);

        // Enable wiggle inside a high phase while gated off.
        @(negedge clk);
        #1;
        en = 1'b0; te = 1'b0;
        @(posedge clk);
        #1;
        s = p0;
        en = 1'b1; #1 en = 1'b0; #1 en = 1'b1; #1 en = 1'b0;
        chk("wiggle off level", int'(c0), 0);
        chk("wiggle off edges", p0 - s, 0);

        // Enable dip inside a high phase while gated on.
        @(negedge clk);
        #1;
        en = 1'b1;
        @(posedge clk);
        #1;
        s = n0;
        en = 1'b0; #1 en = 1'b1; #1 en = 1'b0;
        #1;
        chk("wiggle on level", int'(c0), 1);
        chk("wiggle on no fall", n0 - s, 0);
        @(posedge clk);
        #1;
        chk("gate closes next cycle", int'(c0), 0);

        // Bypass build ignores reset and enables.
        s = pb; k = pk;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bypass hi%0d", i), int'(cb), 1);
            @(negedge clk);
            #1;
            chk($sformatf("bypass lo%0d", i), int'(cb), 0);
        end
        chk("bypass edges", pb - s, pk - k);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
